// File: rtl/regfile_reader.sv
// Sweeps a range of register-file addresses and streams each word out
// over a valid/ready port, one word per address, wrapping past the top.
module regfile_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  reset_all,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_WIDTH-1:0] first_addr,
   input  logic [ADDR_WIDTH-1:0] last_addr,
   output logic [ADDR_WIDTH-1:0] rf_address,
   input  logic [DATA_WIDTH-1:0] rf_q,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      OUT
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] last_q;
   logic                  xfer;

   assign xfer = rd_valid && rd_ready;
   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge reset_all) begin
      if (reset_all) begin
         state      <= IDLE;
         last_q     <= '0;
         rf_address <= '0;
         rd_valid   <= 1'b0;
         rd_data    <= '0;
         rd_addr    <= '0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  last_q     <= last_addr;
                  rf_address <= first_addr;
                  state      <= SETUP;
               end
            end
            SETUP: begin
               if (abort) begin
                  state <= IDLE;
               end else begin
                  rd_data  <= rf_q;
                  rd_addr  <= rf_address;
                  rd_valid <= 1'b1;
                  state    <= OUT;
               end
            end
            OUT: begin
               // abort wins over a transfer landing on the same edge
               if (abort) begin
                  rd_valid <= 1'b0;
                  state    <= IDLE;
               end else if (xfer) begin
                  rd_valid <= 1'b0;
                  if (rf_address == last_q) begin
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     rf_address <= rf_address + 1'b1;
                     state      <= SETUP;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_reader.sv
// Scoreboard bench for regfile_reader: a sweep model queues the expected
// words, a negedge monitor pops and compares each transfer.
module tb_regfile_reader;

   typedef struct {
      logic [2:0] a;
      logic [7:0] d;
      bit         last;
   } exp_t;

   logic       clk;
   logic       reset_all;
   logic       start;
   logic       abort;
   logic [2:0] first_addr;
   logic [2:0] last_addr;
   logic [2:0] rf_address;
   logic [7:0] rf_q;
   logic       rd_valid;
   logic       rd_ready;
   logic [7:0] rd_data;
   logic [2:0] rd_addr;
   logic       busy;
   logic       done;

   logic [7:0] mem [8];
   exp_t       q[$];
   bit         sweep_on;
   bit         pend_done;
   bit         rand_ready;
   int         cyc;
   int         start_cyc;
   int         last_xfer_cyc;
   int         vectors;
   int         miscompares;

   regfile_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
      .clk       (clk),
      .reset_all (reset_all),
      .start     (start),
      .abort     (abort),
      .first_addr(first_addr),
      .last_addr (last_addr),
      .rf_address(rf_address),
      .rf_q      (rf_q),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .rd_data   (rd_data),
      .rd_addr   (rd_addr),
      .busy      (busy),
      .done      (done)
   );

   assign rf_q = mem[rf_address];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic fail(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: got timeout/unexpected expected event", name);
   endtask

   // monitor: transfers happen at the posedge following this negedge
   initial begin : monitor
      bit         prev_stall;
      logic [7:0] prev_d;
      logic [2:0] prev_a;
      bit         new_pend;
      exp_t       e;
      prev_stall = 0;
      prev_d = '0;
      prev_a = '0;
      forever begin
         @(negedge clk);
         if (reset_all) begin
            prev_stall = 0;
         end else begin
            chk("done", done, pend_done);
            if (done) chk("busy_at_done", busy, 0);
            new_pend = 0;
            if (prev_stall) begin
               chk("stall_valid", rd_valid, 1);
               chk("stall_data", rd_data, prev_d);
               chk("stall_addr", rd_addr, prev_a);
            end
            if (rd_valid && rd_ready && !abort) begin
               if (q.size() == 0) begin
                  fail("unexpected_word");
               end else begin
                  e = q.pop_front();
                  chk("rd_addr", rd_addr, e.a);
                  chk("rd_data", rd_data, e.d);
                  if (e.last) begin
                     new_pend = 1;
                     sweep_on = 0;
                     last_xfer_cyc = cyc + 1;
                  end
               end
            end
            prev_stall = rd_valid && !rd_ready && !abort;
            prev_d = rd_data;
            prev_a = rd_addr;
            pend_done = new_pend;
         end
      end
   end

   initial begin : ready_drv
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) rd_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] f, input logic [2:0] l,
                        input bit with_abort);
      int         n;
      logic [2:0] a;
      exp_t       e;
      if (!sweep_on) begin
         n = ((int'(l) - int'(f)) & 7) + 1;
         for (int i = 0; i < n; i++) begin
            a = 3'(int'(f) + i);
            e.a = a;
            e.d = mem[a];
            e.last = (i == n - 1);
            q.push_back(e);
         end
         sweep_on = 1;
         start_cyc = cyc;
         abort = with_abort;
      end
      start = 1'b1;
      first_addr = f;
      last_addr = l;
      tick();
      start = 1'b0;
      abort = 1'b0;
      first_addr = 3'($urandom);
      last_addr = 3'($urandom);
   endtask

   task automatic do_abort();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      q.delete();
      sweep_on = 0;
      pend_done = 0;
      chk("abort_valid", rd_valid, 0);
      chk("abort_busy", busy, 0);
   endtask

   task automatic wait_idle(input int bound, input bit rand_abort);
      int k;
      k = 0;
      while (sweep_on && k < bound) begin
         if (rand_abort && $urandom_range(0, 30) == 0) do_abort();
         else tick();
         k++;
      end
      if (sweep_on) begin
         fail("sweep_timeout");
         q.delete();
         sweep_on = 0;
      end
      tick();
   endtask

   task automatic wait_word(input logic [2:0] a);
      int k;
      k = 0;
      while (!(rd_valid && rd_addr == a) && k < 100) begin
         tick();
         k++;
      end
      if (!(rd_valid && rd_addr == a)) fail("wait_word");
   endtask

   task automatic fill_rand();
      for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      sweep_on = 0;
      pend_done = 0;
      rand_ready = 0;
      last_xfer_cyc = 0;
      start_cyc = 0;
      reset_all = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      first_addr = '0;
      last_addr = '0;
      rd_ready = 1'b0;
      for (int i = 0; i < 8; i++) mem[i] = 8'(8'hAA + i);
      #12;
      chk("rst_rf_address", rf_address, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_valid", rd_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      tick();
      reset_all = 1'b0;
      rd_ready = 1'b1;
      tick();

      // full sweep with latency checks
      issue(3'd0, 3'd7, 0);
      chk("setup_valid", rd_valid, 0);
      chk("setup_busy", busy, 1);
      tick();
      chk("first_valid", rd_valid, 1);
      chk("first_addr", rd_addr, 0);
      chk("first_data", rd_data, 8'hAA);
      wait_idle(100, 0);
      chk("sweep_latency", last_xfer_cyc - (start_cyc + 1), 16);

      // wrapping sweep
      issue(3'd6, 3'd1, 0);
      wait_idle(100, 0);

      // back-pressure on word 2
      issue(3'd0, 3'd7, 0);
      wait_word(3'd2);
      rd_ready = 1'b0;
      repeat (3) tick();
      rd_ready = 1'b1;
      wait_idle(100, 0);

      // single word, second start ignored while busy
      issue(3'd3, 3'd3, 0);
      issue(3'd5, 3'd2, 0);
      wait_idle(100, 0);

      // abort in OUT of word 4, then a clean sweep
      issue(3'd0, 3'd7, 0);
      wait_word(3'd4);
      do_abort();
      tick();
      chk("post_abort_busy", busy, 0);
      fill_rand();
      issue(3'd0, 3'd7, 0);
      wait_idle(100, 0);

      // asynchronous reset mid-sweep
      issue(3'd2, 3'd6, 0);
      wait_word(3'd3);
      #2;
      reset_all = 1'b1;
      #1;
      q.delete();
      sweep_on = 0;
      pend_done = 0;
      chk("arst_rf_address", rf_address, 0);
      chk("arst_rd_data", rd_data, 0);
      chk("arst_rd_addr", rd_addr, 0);
      chk("arst_valid", rd_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      tick();
      tick();
      reset_all = 1'b0;
      repeat (4) begin
         tick();
         chk("post_rst_busy", busy, 0);
         chk("post_rst_valid", rd_valid, 0);
      end

      // randomized sweeps with random back-pressure and aborts
      rand_ready = 1;
      for (int s = 0; s < 40; s++) begin
         fill_rand();
         issue(3'($urandom), 3'($urandom), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 2) == 0) issue(3'($urandom), 3'($urandom), 0);
         wait_idle(300, 1);
      end
      rand_ready = 0;
      rd_ready = 1'b1;
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
